system_sysid_checker: RTL and testbench

Avalon-MM master that reads a `system_sysid`-style identification slave and checks it against build-time expected values. The slave has two words: word 0 is the system ID and word 1 is the timestamp. The block sits beside the CPU in the system interconnect. It gives boot logic a hardware pass/fail on "FPGA image matches software build" without processor involvement, and is retried and timeout-guarded against a stalled fabric.

---
 rtl/system_sysid_pkg.sv | 18 +
 rtl/system_sysid_checker_timer.sv | 46 ++++
 rtl/system_sysid_checker.sv | 155 +++++++++++++++
 tb/tb_system_sysid_checker.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM states, slave word map, data width.
package system_sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StGap,
    StCheck,
    StDone
  } sysid_state_e;

endpackage

// File: rtl/system_sysid_checker_timer.sv
// Per-attempt waitrequest counter and per-check retry counter for the sysid checker.
module system_sysid_checker_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic wait_en,
  input  logic retry_inc,
  input  logic retry_clear,
  output logic expired,
  output logic retries_exhausted
);

  localparam int unsigned WaitW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 2);

  logic [WaitW-1:0]  wait_cnt_q;
  logic [RetryW-1:0] retry_cnt_q;

  // Expiry is flagged on the last stalled cycle so the attempt lasts exactly TIMEOUT_CYCLES.
  assign expired           = wait_en && (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1));
  assign retries_exhausted = (retry_cnt_q >= RetryW'(MAX_RETRIES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (clear) begin
      wait_cnt_q <= '0;
    end else if (wait_en) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_cnt_q <= '0;
    end else if (retry_clear) begin
      retry_cnt_q <= '0;
    end else if (retry_inc) begin
      retry_cnt_q <= retry_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/system_sysid_checker.sv
// Avalon-MM master that reads a sysid slave and checks ID/timestamp against build-time values.
// Optional SYSID_CHECKER_AUTOSTART_EN: fire one check automatically right after reset.
module system_sysid_checker
  import system_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1393717012,
  parameter int unsigned             TIMEOUT_CYCLES     = 255,
  parameter int unsigned             MAX_RETRIES        = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  sysid_state_e state_q;
  sysid_state_e gap_ret_q;

  logic start_eff;
  logic in_read;
  logic tmr_wait;
  logic tmr_clear;
  logic retry_inc;
  logic retry_clear;
  logic expired;
  logic exhausted;

`ifdef SYSID_CHECKER_AUTOSTART_EN
  logic auto_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end

  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  assign in_read     = (state_q == StRdId) || (state_q == StRdTs);
  assign tmr_wait    = in_read && avm_waitrequest;
  // Counter is nonzero only across an unbroken stall, which clears it on every state entry.
  assign tmr_clear   = !tmr_wait || expired;
  assign retry_inc   = expired && !exhausted;
  assign retry_clear = (state_q == StIdle) && start_eff;

  system_sysid_checker_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_timer (
    .clock             (clock),
    .reset             (reset),
    .clear             (tmr_clear),
    .wait_en           (tmr_wait),
    .retry_inc         (retry_inc),
    .retry_clear       (retry_clear),
    .expired           (expired),
    .retries_exhausted (exhausted)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gap_ret_q   <= StRdId;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_eff) begin
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            state_q     <= StRdId;
          end
        end
        StRdId, StRdTs: begin
          if (!avm_waitrequest) begin
            if (state_q == StRdId) begin
              id_value    <= avm_readdata;
              avm_address <= SYSID_ADDR_TS;
              state_q     <= StRdTs;
            end else begin
              ts_value    <= avm_readdata;
              avm_read    <= 1'b0;
              avm_address <= SYSID_ADDR_ID;
              state_q     <= StCheck;
            end
          end else if (expired) begin
            avm_read <= 1'b0;
            if (!exhausted) begin
              gap_ret_q <= state_q;
              state_q   <= StGap;
            end else begin
              avm_address <= SYSID_ADDR_ID;
              timeout     <= 1'b1;
              done        <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StGap: begin
          avm_read <= 1'b1;
          state_q  <= gap_ret_q;
        end
        StCheck: begin
          id_mismatch <= (id_value != EXPECTED_ID);
          ts_mismatch <= (ts_value != EXPECTED_TIMESTAMP);
          pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
          done        <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Scoreboard bench for system_sysid_checker: scripted slave, queue of predicted results, done monitor.
module tb_system_sysid_checker;

  localparam int unsigned T          = 255;
  localparam int unsigned R          = 3;
  localparam logic [31:0] EXP_ID     = 32'd0;
  localparam logic [31:0] EXP_TS     = 32'd1393717012;
  localparam int          STUCK      = 100000;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        pass;
  logic        id_mismatch;
  logic        ts_mismatch;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  system_sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_mismatch     (id_mismatch),
    .ts_mismatch     (ts_mismatch),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  typedef struct {
    int unsigned done_cyc;
    logic        p;
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          dones = 0;
  int unsigned cyc = 0;

  // Slave script: waitrequest cycles for each read attempt of the current check, in order.
  int          stall_cfg[8];
  logic [31:0] slv_id;
  logic [31:0] slv_ts;
  int          att;
  int          wc;
  logic        prev_read;
  logic        prev_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the attempt script with the retry/timeout rules, summing cycle costs.
  function automatic exp_t model(input int unsigned se);
    exp_t        e;
    int          i;
    int          retries;
    int unsigned cost;
    bit          to;
    bit          got;
    int          s;
    logic [31:0] cap[2];
    i = 0; retries = 0; cost = 0; to = 0;
    cap[0] = '0; cap[1] = '0;
    for (int w = 0; w < 2; w++) begin
      got = 0;
      while (!got && !to) begin
        s = stall_cfg[i];
        i++;
        if (s < int'(T)) begin
          cost += s + 1;
          cap[w] = (w == 1) ? slv_ts : slv_id;
          got = 1;
        end else if (retries < int'(R)) begin
          retries++;
          cost += T + 1;
        end else begin
          cost += T;
          to = 1;
        end
      end
    end
    e.done_cyc = se + cost + (to ? 0 : 1);
    e.to  = to;
    e.idv = cap[0];
    e.tsv = cap[1];
    e.idm = !to && (cap[0] != EXP_ID);
    e.tsm = !to && (cap[1] != EXP_TS);
    e.p   = !to && !e.idm && !e.tsm;
    return e;
  endfunction

  always @(negedge clock) begin
    int idx;
    if (reset) begin
      att = -1;
      prev_read = 1'b0;
      prev_addr = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (done) att = -1;
      if (avm_read) begin
        if (!prev_read || (avm_address != prev_addr)) begin
          att++;
          wc = 0;
        end
        idx = (att > 7) ? 7 : ((att < 0) ? 0 : att);
        avm_waitrequest = (wc < stall_cfg[idx]);
        wc++;
        avm_readdata = avm_address ? slv_ts : slv_id;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = $urandom;
      end
      prev_read = avm_read;
      prev_addr = avm_address;
    end
  end

  logic m_read, m_wr, m_addr;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      m_read = 1'b0;
      m_wr = 1'b0;
    end else begin
      if (m_read && m_wr && avm_read) chk("addr_stable", 32'(avm_address), 32'(m_addr));
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("pass", 32'(pass), 32'(e.p));
          chk("id_mismatch", 32'(id_mismatch), 32'(e.idm));
          chk("ts_mismatch", 32'(ts_mismatch), 32'(e.tsm));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("id_value", id_value, e.idv);
          chk("ts_value", ts_value, e.tsv);
          chk("busy_at_done", 32'(busy), 32'd1);
        end
      end
      m_read = avm_read;
      m_wr = avm_waitrequest;
      m_addr = avm_address;
    end
  end

  task automatic set_cfg(input int s0, input int s1, input int s2, input int s3, input int s4,
                         input logic [31:0] id, input logic [31:0] ts);
    stall_cfg[0] = s0; stall_cfg[1] = s1; stall_cfg[2] = s2;
    stall_cfg[3] = s3; stall_cfg[4] = s4;
    stall_cfg[5] = 0;  stall_cfg[6] = 0;  stall_cfg[7] = 0;
    slv_id = id;
    slv_ts = ts;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int k;
    d0 = dones;
    k = 0;
    while (dones == d0 && k < limit) begin
      @(posedge clock);
      k++;
    end
    #1;
    if (dones == d0) begin
      compared++;
      mismatched++;
      $display("FAIL wait_done: got no done within %0d cycles, expected one", limit);
      exp_q.delete();
    end
  endtask

  task automatic start_check(input bit hold);
    @(posedge clock);
    #1;
    start = 1'b1;
    exp_q.push_back(model(cyc + 1));
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_check();
    start_check(1'b0);
    wait_done(2000);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
`ifdef SYSID_CHECKER_AUTOSTART_EN
    exp_q.push_back(model(cyc + 1));
    wait_done(2000);
`endif
  endtask

  function automatic int pick_stall();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 4));
    if (r < 17) return int'(T) - 1;
    return int'(T);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rid;
    logic [31:0] rts;
    reset = 1'b1;
    start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, EXP_ID, EXP_TS);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
    release_reset();

    set_cfg(0, 0, 0, 0, 0, EXP_ID, EXP_TS);
    run_check();
    set_cfg(0, 0, 0, 0, 0, EXP_ID, 32'h12345678);
    run_check();
    set_cfg(int'(T) - 1, 0, 0, 0, 0, EXP_ID, EXP_TS);
    run_check();
    set_cfg(STUCK, STUCK, STUCK, STUCK, STUCK, EXP_ID, EXP_TS);
    run_check();
    set_cfg(int'(T), 0, int'(T), int'(T), 0, EXP_ID, EXP_TS);
    run_check();
    set_cfg(int'(T), int'(T), 0, int'(T), int'(T), 32'hdeadbeef, EXP_TS);
    run_check();

    // Reset while the timestamp read is stalled.
    set_cfg(0, STUCK, 0, 0, 0, EXP_ID, EXP_TS);
    start_check(1'b0);
    repeat (5) @(posedge clock);
    #1;
    chk("pre_reset_read", {30'd0, avm_read, avm_address}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_read", 32'(avm_read), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_id_value", id_value, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    set_cfg(0, 0, 0, 0, 0, EXP_ID, EXP_TS);
    release_reset();
    run_check();

    // Start held high through a check and into the following IDLE cycle.
    set_cfg(0, 2, 0, 0, 0, EXP_ID, EXP_TS);
    start_check(1'b1);
    wait_done(2000);
    exp_q.push_back(model(cyc + 1));
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(2000);
    repeat (10) @(posedge clock);

    for (int k = 0; k < 25; k++) begin
      rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      set_cfg(pick_stall(), pick_stall(), pick_stall(), pick_stall(), pick_stall(), rid, rts);
      run_check();
    end

    repeat (5) @(posedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
